v_instr_issue_queue: RTL and testbench

// Decoupling buffer between scalar_core and vector_core. Accepts vector instructions with rs1/rs2 operand values

---
 rtl/v_issue_pkg.sv | 22 ++
 rtl/v_issue_if.sv | 23 ++
 rtl/v_issue_fifo.sv | 59 +++++
 rtl/v_instr_issue_queue.sv | 84 ++++++++
 tb/tb_v_instr_issue_queue.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/v_issue_pkg.sv
// Shared types and opcode decode for the vector instruction issue queue.
package v_issue_pkg;

  localparam logic [6:0] OPC_VLOAD  = 7'b0000111;
  localparam logic [6:0] OPC_VSTORE = 7'b0100111;
  localparam logic [6:0] OPC_OPV    = 7'b1010111;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } v_issue_entry_t;

  function automatic logic is_vload(logic [31:0] instr);
    return instr[6:0] == OPC_VLOAD;
  endfunction

  function automatic logic is_vstore(logic [31:0] instr);
    return instr[6:0] == OPC_VSTORE;
  endfunction

endpackage

// File: rtl/v_issue_if.sv
// Issue handshake bundle: scalar-core push side and vector-core pop side.
interface v_issue_if;
  logic        v_instr_valid_i;
  logic [31:0] v_instruction_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic        vector_stall_o;
  logic        v_instr_valid_o;
  logic [31:0] v_instruction_o;
  logic [31:0] rs1_o;
  logic [31:0] rs2_o;
  logic        v_instr_ready_i;

  modport slave (
    input  v_instr_valid_i, v_instruction_i, rs1_i, rs2_i, v_instr_ready_i,
    output vector_stall_o, v_instr_valid_o, v_instruction_o, rs1_o, rs2_o
  );

  modport master (
    output v_instr_valid_i, v_instruction_i, rs1_i, rs2_i, v_instr_ready_i,
    input  vector_stall_o, v_instr_valid_o, v_instruction_o, rs1_o, rs2_o
  );
endinterface

// File: rtl/v_issue_fifo.sv
// In-order entry storage; head entry is always visible on rdata_o.
module v_issue_fifo
  import v_issue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  v_issue_entry_t           wdata_i,
  input  logic                     pop_i,
  output v_issue_entry_t           rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  v_issue_entry_t mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic           wr_en, rd_en;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign wr_en = push_i & ~full_o;
  assign rd_en = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_en && !rd_en)      count_d = count_q + 1'b1;
    else if (!wr_en && rd_en) count_d = count_q - 1'b1;
  end

  // Storage is cleared on reset so the data outputs read as zero afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/v_instr_issue_queue.sv
// Scalar-to-vector issue queue with back-pressure and outstanding load/store tracking.
module v_instr_issue_queue
  import v_issue_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int OUTST_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  v_issue_if.slave   bus,
  input  logic       v_load_done_i,
  input  logic       v_store_done_i,
  output logic       all_v_loads_executed_o,
  output logic       all_v_stores_executed_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic               is_ld, is_st, push, pop;
  logic               fifo_full, fifo_empty;
  logic [CNT_W-1:0]   fifo_count_unused;
  v_issue_entry_t     wr_entry, head;
  logic [OUTST_W-1:0] ld_cnt_q, ld_cnt_d, st_cnt_q, st_cnt_d;
  logic               ld_inc, ld_dec, st_inc, st_dec;

  assign is_ld = is_vload(bus.v_instruction_i);
  assign is_st = is_vstore(bus.v_instruction_i);

  // Stall depends only on registered state and the presented instruction, never on ready.
  assign bus.vector_stall_o = fifo_full
                            | (is_ld & (ld_cnt_q == '1))
                            | (is_st & (st_cnt_q == '1));

  assign push = bus.v_instr_valid_i & ~bus.vector_stall_o;
  assign pop  = bus.v_instr_valid_o & bus.v_instr_ready_i;

  assign wr_entry = '{instr: bus.v_instruction_i, rs1: bus.rs1_i, rs2: bus.rs2_i};

  v_issue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (wr_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count_unused)
  );

  assign bus.v_instr_valid_o = ~fifo_empty;
  assign bus.v_instruction_o = head.instr;
  assign bus.rs1_o           = head.rs1;
  assign bus.rs2_o           = head.rs2;

  // Done pulses at zero are dropped so the counters never wrap below zero.
  assign ld_inc = push & is_ld;
  assign ld_dec = v_load_done_i & (ld_cnt_q != '0);
  assign st_inc = push & is_st;
  assign st_dec = v_store_done_i & (st_cnt_q != '0);

  always_comb begin
    ld_cnt_d = ld_cnt_q;
    st_cnt_d = st_cnt_q;
    if (ld_inc && !ld_dec)      ld_cnt_d = ld_cnt_q + 1'b1;
    else if (!ld_inc && ld_dec) ld_cnt_d = ld_cnt_q - 1'b1;
    if (st_inc && !st_dec)      st_cnt_d = st_cnt_q + 1'b1;
    else if (!st_inc && st_dec) st_cnt_d = st_cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ld_cnt_q <= '0;
      st_cnt_q <= '0;
    end else begin
      ld_cnt_q <= ld_cnt_d;
      st_cnt_q <= st_cnt_d;
    end
  end

  assign all_v_loads_executed_o  = (ld_cnt_q == '0);
  assign all_v_stores_executed_o = (st_cnt_q == '0);

endmodule

// File: tb/tb_v_instr_issue_queue.sv
// Directed bench for the vector issue queue (DEPTH=4, OUTST_W=2).
module tb_v_instr_issue_queue;

  logic clk = 1'b0;
  logic reset;
  logic v_load_done_i, v_store_done_i;
  logic all_v_loads_executed_o, all_v_stores_executed_o;
  int   errors = 0;
  int   checks = 0;

  v_issue_if bus_if ();

  v_instr_issue_queue #(.DEPTH(4), .OUTST_W(2)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .bus                     (bus_if.slave),
    .v_load_done_i           (v_load_done_i),
    .v_store_done_i          (v_store_done_i),
    .all_v_loads_executed_o  (all_v_loads_executed_o),
    .all_v_stores_executed_o (all_v_stores_executed_o)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    bus_if.v_instr_valid_i = v;
    bus_if.v_instruction_i = ins;
    bus_if.rs1_i           = a;
    bus_if.rs2_i           = b;
  endtask

  function automatic logic [31:0] opv(input int i);
    return 32'h1000_0057 | (32'(i) << 12);
  endfunction

  localparam logic [31:0] LOAD  = 32'h0000_0007;
  localparam logic [31:0] STORE = 32'h0000_0027;

  initial begin
    reset = 1'b1;
    v_load_done_i = 1'b0;
    v_store_done_i = 1'b0;
    bus_if.v_instr_ready_i = 1'b0;
    drive(1'b0, '0, '0, '0);
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst_valid", {31'b0, bus_if.v_instr_valid_o}, 32'd0);
    chk("rst_stall", {31'b0, bus_if.vector_stall_o}, 32'd0);
    chk("rst_ld_flag", {31'b0, all_v_loads_executed_o}, 32'd1);
    chk("rst_st_flag", {31'b0, all_v_stores_executed_o}, 32'd1);
    chk("rst_instr", bus_if.v_instruction_o, 32'd0);

    // single OP-V push, no bypass
    drive(1'b1, 32'h0200_8057, 32'h10, 32'h20);
    #1;
    chk("t1_nobypass", {31'b0, bus_if.v_instr_valid_o}, 32'd0);
    step();
    drive(1'b0, '0, '0, '0);
    chk("t1_valid", {31'b0, bus_if.v_instr_valid_o}, 32'd1);
    chk("t1_instr", bus_if.v_instruction_o, 32'h0200_8057);
    chk("t1_rs1", bus_if.rs1_o, 32'h10);
    chk("t1_rs2", bus_if.rs2_o, 32'h20);
    bus_if.v_instr_ready_i = 1'b1;
    step();
    bus_if.v_instr_ready_i = 1'b0;
    chk("t1_popped", {31'b0, bus_if.v_instr_valid_o}, 32'd0);
    chk("t1_ld_flag", {31'b0, all_v_loads_executed_o}, 32'd1);
    chk("t1_st_flag", {31'b0, all_v_stores_executed_o}, 32'd1);

    // fill to DEPTH, fifth push held, full+pop refuses the push
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, opv(i), 32'h100 + 32'(i), 32'h200 + 32'(i));
      #1;
      chk("t2_nostall", {31'b0, bus_if.vector_stall_o}, 32'd0);
      step();
    end
    drive(1'b1, opv(4), 32'h104, 32'h204);
    #1;
    chk("t2_full_stall", {31'b0, bus_if.vector_stall_o}, 32'd1);
    step();
    chk("t2_held_stall", {31'b0, bus_if.vector_stall_o}, 32'd1);
    chk("t2_head0", bus_if.v_instruction_o, opv(0));
    bus_if.v_instr_ready_i = 1'b1;
    #1;
    chk("t3_stall_no_ready_dep", {31'b0, bus_if.vector_stall_o}, 32'd1);
    step();
    bus_if.v_instr_ready_i = 1'b0;
    #1;
    chk("t3_stall_drop", {31'b0, bus_if.vector_stall_o}, 32'd0);
    chk("t3_head1", bus_if.v_instruction_o, opv(1));
    step();
    drive(1'b0, '0, '0, '0);
    #1;
    chk("t2_full_again", {31'b0, bus_if.vector_stall_o}, 32'd1);
    bus_if.v_instr_ready_i = 1'b1;
    for (int i = 1; i < 5; i++) begin
      chk("t2_order_instr", bus_if.v_instruction_o, opv(i));
      chk("t2_order_rs1", bus_if.rs1_o, 32'h100 + 32'(i));
      step();
    end
    chk("t2_drained", {31'b0, bus_if.v_instr_valid_o}, 32'd0);

    // steady push+pop at count 2
    bus_if.v_instr_ready_i = 1'b0;
    drive(1'b1, opv(10), 32'h0, 32'h0);
    step();
    drive(1'b1, opv(11), 32'h0, 32'h0);
    step();
    bus_if.v_instr_ready_i = 1'b1;
    for (int k = 12; k < 16; k++) begin
      drive(1'b1, opv(k), 32'h0, 32'h0);
      #1;
      chk("t3_tp_valid", {31'b0, bus_if.v_instr_valid_o}, 32'd1);
      chk("t3_tp_head", bus_if.v_instruction_o, opv(k - 2));
      chk("t3_tp_stall", {31'b0, bus_if.vector_stall_o}, 32'd0);
      step();
    end
    drive(1'b0, '0, '0, '0);
    chk("t3_rem0", bus_if.v_instruction_o, opv(14));
    step();
    chk("t3_rem1", bus_if.v_instruction_o, opv(15));
    step();
    chk("t3_empty", {31'b0, bus_if.v_instr_valid_o}, 32'd0);

    // load/store counters and flags
    drive(1'b1, LOAD, 32'h0, 32'h0);
    step();
    drive(1'b1, STORE, 32'h0, 32'h0);
    step();
    drive(1'b0, '0, '0, '0);
    chk("t4_ld_pending", {31'b0, all_v_loads_executed_o}, 32'd0);
    chk("t4_st_pending", {31'b0, all_v_stores_executed_o}, 32'd0);
    v_load_done_i = 1'b1;
    step();
    v_load_done_i = 1'b0;
    chk("t4_ld_done", {31'b0, all_v_loads_executed_o}, 32'd1);
    chk("t4_st_still", {31'b0, all_v_stores_executed_o}, 32'd0);
    v_store_done_i = 1'b1;
    step();
    v_store_done_i = 1'b0;
    chk("t4_st_done", {31'b0, all_v_stores_executed_o}, 32'd1);
    v_load_done_i = 1'b1;
    v_store_done_i = 1'b1;
    step();
    v_load_done_i = 1'b0;
    v_store_done_i = 1'b0;
    chk("t4_ld_at0", {31'b0, all_v_loads_executed_o}, 32'd1);
    chk("t4_st_at0", {31'b0, all_v_stores_executed_o}, 32'd1);
    drive(1'b1, LOAD, 32'h0, 32'h0);
    step();
    drive(1'b0, '0, '0, '0);
    chk("t4_no_underflow", {31'b0, all_v_loads_executed_o}, 32'd0);
    v_load_done_i = 1'b1;
    step();
    v_load_done_i = 1'b0;
    chk("t4_back_to_0", {31'b0, all_v_loads_executed_o}, 32'd1);

    // load counter saturation (max 3 with OUTST_W=2)
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, LOAD, 32'h0, 32'h0);
      step();
    end
    #1;
    chk("t5_ld_max_stall", {31'b0, bus_if.vector_stall_o}, 32'd1);
    drive(1'b1, opv(20), 32'h0, 32'h0);
    #1;
    chk("t5_opv_ok", {31'b0, bus_if.vector_stall_o}, 32'd0);
    step();
    drive(1'b0, '0, '0, '0);
    v_load_done_i = 1'b1;
    step();
    v_load_done_i = 1'b0;
    drive(1'b1, LOAD, 32'h0, 32'h0);
    #1;
    chk("t5_ld_at2", {31'b0, bus_if.vector_stall_o}, 32'd0);
    v_load_done_i = 1'b1;
    step();
    v_load_done_i = 1'b0;
    #1;
    chk("t5_simul_keeps", {31'b0, bus_if.vector_stall_o}, 32'd0);
    step();
    chk("t5_ld_max_again", {31'b0, bus_if.vector_stall_o}, 32'd1);
    v_load_done_i = 1'b1;
    #1;
    chk("t5_done_at_max_refuse", {31'b0, bus_if.vector_stall_o}, 32'd1);
    step();
    v_load_done_i = 1'b0;
    #1;
    chk("t5_ld_dec", {31'b0, bus_if.vector_stall_o}, 32'd0);
    drive(1'b0, '0, '0, '0);

    // reset mid-operation
    bus_if.v_instr_ready_i = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, opv(30 + i), 32'h300, 32'h400);
      step();
    end
    chk("t6_pre_valid", {31'b0, bus_if.v_instr_valid_o}, 32'd1);
    chk("t6_pre_ld", {31'b0, all_v_loads_executed_o}, 32'd0);
    drive(1'b1, opv(40), 32'h500, 32'h600);
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(1'b0, '0, '0, '0);
    #1;
    chk("t6_valid", {31'b0, bus_if.v_instr_valid_o}, 32'd0);
    chk("t6_ld_flag", {31'b0, all_v_loads_executed_o}, 32'd1);
    chk("t6_st_flag", {31'b0, all_v_stores_executed_o}, 32'd1);
    chk("t6_stall", {31'b0, bus_if.vector_stall_o}, 32'd0);
    chk("t6_data0", bus_if.rs1_o, 32'd0);
    drive(1'b1, opv(50), 32'hAAAA, 32'hBBBB);
    step();
    drive(1'b0, '0, '0, '0);
    chk("t6_new_valid", {31'b0, bus_if.v_instr_valid_o}, 32'd1);
    chk("t6_new_instr", bus_if.v_instruction_o, opv(50));
    chk("t6_new_rs2", bus_if.rs2_o, 32'hBBBB);
    bus_if.v_instr_ready_i = 1'b1;
    step();
    chk("t6_no_stale", {31'b0, bus_if.v_instr_valid_o}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
